instruction_encode: RTL and testbench

INSTRUCTION_ENCODE -- requirements
Module: instruction_encode

---
 rtl/cpu_package.sv | 34 +++
 rtl/instruction_pack.sv | 76 +++++++
 rtl/instruction_encode.sv | 83 ++++++++
 tb/tb_instruction_encode.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_package.sv
// Shared encode/decode definitions: instruction formats, field positions
// and the signed-range helper used by the immediate checks.
package cpu_package;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } instruction_type_t;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    typedef struct packed {
        logic [31:0] instruction;
        logic        imm_error;
    } enc_word_t;

    // True when bits [31:msb] are all equal, i.e. v fits a signed (msb+1)-bit field.
    function automatic logic sext_fits(input logic [31:0] v,
                                       input int unsigned msb);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << msb;
        return ((v & m) == m) || ((v & m) == 32'h0);
    endfunction

endpackage

// File: rtl/instruction_pack.sv
// Combinational field packer and immediate range checker for all
// six base instruction formats.
module instruction_pack
    import cpu_package::*;
(
    input  instruction_type_t instruction_type,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       immediate,
    output logic [31:0]       instruction,
    output logic              imm_error
);

    always_comb begin
        instruction = 32'h0;
        imm_error   = 1'b0;
        instruction[OPCODE_LSB +: 7] = opcode;
        case (instruction_type)
            R_TYPE: begin
                instruction[RD_LSB +: 5]     = rd;
                instruction[FUNCT3_LSB +: 3] = funct3;
                instruction[RS1_LSB +: 5]    = rs1;
                instruction[RS2_LSB +: 5]    = rs2;
                instruction[FUNCT7_LSB +: 7] = funct7;
            end
            I_TYPE: begin
                instruction[RD_LSB +: 5]     = rd;
                instruction[FUNCT3_LSB +: 3] = funct3;
                instruction[RS1_LSB +: 5]    = rs1;
                instruction[31:20]           = immediate[11:0];
                imm_error = !sext_fits(immediate, 11);
            end
            S_TYPE: begin
                instruction[31:25]           = immediate[11:5];
                instruction[RS2_LSB +: 5]    = rs2;
                instruction[RS1_LSB +: 5]    = rs1;
                instruction[FUNCT3_LSB +: 3] = funct3;
                instruction[11:7]            = immediate[4:0];
                imm_error = !sext_fits(immediate, 11);
            end
            B_TYPE: begin
                instruction[31]              = immediate[12];
                instruction[30:25]           = immediate[10:5];
                instruction[RS2_LSB +: 5]    = rs2;
                instruction[RS1_LSB +: 5]    = rs1;
                instruction[FUNCT3_LSB +: 3] = funct3;
                instruction[11:8]            = immediate[4:1];
                instruction[7]               = immediate[11];
                imm_error = !sext_fits(immediate, 12)
                          || immediate[0];
            end
            U_TYPE: begin
                instruction[31:12]       = immediate[31:12];
                instruction[RD_LSB +: 5] = rd;
                imm_error = |immediate[11:0];
            end
            J_TYPE: begin
                instruction[31]          = immediate[20];
                instruction[30:21]       = immediate[10:1];
                instruction[20]          = immediate[11];
                instruction[19:12]       = immediate[19:12];
                instruction[RD_LSB +: 5] = rd;
                imm_error = !sext_fits(immediate, 20)
                          || immediate[0];
            end
            default: begin
                imm_error = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instruction_encode.sv
// Instruction encoder: packs fields per format and queues the result
// in a 2-entry FIFO with valid/ready handshakes on both sides.
module instruction_encode
    import cpu_package::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  instruction_type_t instruction_type,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       immediate,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instruction,
    output logic              imm_error,
    output logic [15:0]       encoded_count
);

    enc_word_t   mem [2];
    enc_word_t   packed_word;
    logic [1:0]  count;
    logic        wptr;
    logic        rptr;
    logic        rst_done;
    logic        push;
    logic        pop;

    instruction_pack u_pack (
        .instruction_type (instruction_type),
        .opcode           (opcode),
        .rd               (rd),
        .rs1              (rs1),
        .rs2              (rs2),
        .funct3           (funct3),
        .funct7           (funct7),
        .immediate        (immediate),
        .instruction      (packed_word.instruction),
        .imm_error        (packed_word.imm_error)
    );

    // rst_done keeps in_ready low until the first edge after reset.
    assign in_ready  = rst_done && (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= 2'd0;
            wptr          <= 1'b0;
            rptr          <= 1'b0;
            rst_done      <= 1'b0;
            encoded_count <= 16'h0;
            mem[0]        <= '0;
            mem[1]        <= '0;
        end else begin
            rst_done <= 1'b1;
            if (push) begin
                mem[wptr] <= packed_word;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr          <= ~rptr;
                encoded_count <= encoded_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign instruction = mem[rptr].instruction;
    assign imm_error   = mem[rptr].imm_error;

endmodule

// File: tb/tb_instruction_encode.sv
// Bench for instruction_encode: format-level reference model, per-cycle
// compare against a queue model, and directed literal checks.
module tb_instruction_encode;
    import cpu_package::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    instruction_type_t itype = R_TYPE;
    logic [6:0]        opc = '0;
    logic [4:0]        rd = '0;
    logic [4:0]        rs1 = '0;
    logic [4:0]        rs2 = '0;
    logic [2:0]        f3 = '0;
    logic [6:0]        f7 = '0;
    logic [31:0]       imm = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       instruction;
    logic              imm_error;
    logic [15:0]       encoded_count;

    int n_checks = 0;
    int n_fail = 0;

    logic [32:0] q[$];
    logic [32:0] popped[$];
    logic [15:0] m_cnt = '0;
    bit          m_rdy = 1'b0;

    instruction_encode dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .instruction_type (itype),
        .opcode           (opc),
        .rd               (rd),
        .rs1              (rs1),
        .rs2              (rs2),
        .funct3           (f3),
        .funct7           (f7),
        .immediate        (imm),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .instruction      (instruction),
        .imm_error        (imm_error),
        .encoded_count    (encoded_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fld(logic [31:0] v, int lo, int w);
        return (v >> lo) & ((32'd1 << w) - 32'd1);
    endfunction

    // Reference: word and error from the format tables, plain arithmetic.
    function automatic logic [32:0] model_encode(
        instruction_type_t t, logic [6:0] op, logic [4:0] d,
        logic [4:0] s1, logic [4:0] s2, logic [2:0] fn3,
        logic [6:0] fn7, logic [31:0] im);
        logic [31:0] w;
        bit          e;
        int          s;
        s = $signed(im);
        e = 1'b0;
        w = 32'(op);
        case (t)
            R_TYPE: w += (32'(d) << 7) + (32'(fn3) << 12) + (32'(s1) << 15)
                       + (32'(s2) << 20) + (32'(fn7) << 25);
            I_TYPE: begin
                w += (32'(d) << 7) + (32'(fn3) << 12) + (32'(s1) << 15)
                   + (fld(im, 0, 12) << 20);
                e = (s < -2048) || (s > 2047);
            end
            S_TYPE: begin
                w += (fld(im, 0, 5) << 7) + (32'(fn3) << 12)
                   + (32'(s1) << 15) + (32'(s2) << 20)
                   + (fld(im, 5, 7) << 25);
                e = (s < -2048) || (s > 2047);
            end
            B_TYPE: begin
                w += (fld(im, 11, 1) << 7) + (fld(im, 1, 4) << 8)
                   + (32'(fn3) << 12) + (32'(s1) << 15) + (32'(s2) << 20)
                   + (fld(im, 5, 6) << 25) + (fld(im, 12, 1) << 31);
                e = (s < -4096) || (s > 4094) || (s % 2 != 0);
            end
            U_TYPE: begin
                w += (32'(d) << 7) + (fld(im, 12, 20) << 12);
                e = fld(im, 0, 12) != 0;
            end
            J_TYPE: begin
                w += (32'(d) << 7) + (fld(im, 12, 8) << 12)
                   + (fld(im, 11, 1) << 20) + (fld(im, 1, 10) << 21)
                   + (fld(im, 20, 1) << 31);
                e = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
            end
            default: e = 1'b0;
        endcase
        return {w, e};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Queue model of the FIFO and pop counter.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_cnt = '0;
            m_rdy = 1'b0;
        end else begin
            bit push_m;
            bit pop_m;
            push_m = in_valid && m_rdy && (q.size() < 2);
            pop_m  = (q.size() > 0) && out_ready;
            if (pop_m) begin
                popped.push_back(q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (push_m)
                q.push_back(model_encode(itype, opc, rd, rs1, rs2, f3, f7, imm));
            m_rdy = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_instr", instruction, 32'd0);
            check("rst_imm_error", 32'(imm_error), 32'd0);
            check("rst_enc_count", 32'(encoded_count), 32'd0);
        end else begin
            check("cyc_in_ready", 32'(in_ready),
                  32'(m_rdy && (q.size() < 2)));
            check("cyc_out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check("cyc_instr", instruction, q[0][32:1]);
                check("cyc_imm_error", 32'(imm_error), 32'(q[0][0]));
            end
            check("cyc_enc_count", 32'(encoded_count), 32'(m_cnt));
        end
    end

    task automatic drive(instruction_type_t t, logic [6:0] op,
                         logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                         logic [2:0] fn3, logic [6:0] fn7, logic [31:0] im);
        itype = t; opc = op; rd = d; rs1 = s1; rs2 = s2;
        f3 = fn3; f7 = fn7; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = in_ready;
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send(instruction_type_t t, logic [6:0] op,
                        logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                        logic [2:0] fn3, logic [6:0] fn7, logic [31:0] im);
        drive(t, op, d, s1, s2, fn3, fn7, im);
        wait_accept();
    endtask

    task automatic expect_head(string name, logic [31:0] w, logic e);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_instr"}, instruction, w);
        check({name, "_err"}, 32'(imm_error), 32'(e));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!out_valid) break;
            @(negedge clk);
            #1;
        end
        check("drain_timeout", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk); #1;
        check("first_edge_ready", 32'(in_ready), 32'd1);

        send(I_TYPE, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFF800);
        expect_head("i_neg2048", 32'h80010093, 1'b0);
        drain();
        send(S_TYPE, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8);
        expect_head("s_sw", 32'h00512423, 1'b0);
        drain();
        send(B_TYPE, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
        expect_head("b_neg4", 32'hFE000EE3, 1'b0);
        drain();
        send(B_TYPE, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        expect_head("b_odd", 32'h00000163, 1'b1);
        drain();
        send(I_TYPE, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
        expect_head("i_2048", 32'h80010093, 1'b1);
        drain();
        send(R_TYPE, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        expect_head("r_add", 32'h002081B3, 1'b0);
        drain();
        send(U_TYPE, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        expect_head("u_lui", 32'h123452B7, 1'b0);
        drain();
        send(J_TYPE, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        expect_head("j_jal", 32'h008000EF, 1'b0);
        drain();

        do_reset();
        popped.delete();
        send(I_TYPE, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        send(I_TYPE, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        check("full_ready_low", 32'(in_ready), 32'd0);
        drive(I_TYPE, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        repeat (3) begin
            check("held_ready", 32'(in_ready), 32'd0);
            check("held_head", instruction, 32'h00100093);
            @(negedge clk); #1;
        end
        out_ready = 1'b1;
        wait_accept();
        drain();
        check("order_size", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            check("order_0", popped[0][32:1], 32'h00100093);
            check("order_1", popped[1][32:1], 32'h00200113);
            check("order_2", popped[2][32:1], 32'h00300193);
        end
        check("order_count", 32'(encoded_count), 32'd3);

        do_reset();
        popped.delete();
        send(I_TYPE, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(I_TYPE, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
            check("pp_valid", 32'(out_valid), 32'd1);
            check("pp_ready", 32'(in_ready), 32'd1);
        end
        drain();
        check("pp_size", 32'(popped.size()), 32'd11);
        if (popped.size() == 11) begin
            check("pp_first", popped[0][32:1], 32'h06400013);
            for (int i = 0; i < 10; i++)
                check("pp_word", popped[i + 1][32:1],
                      (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13);
        end
        check("pp_count", 32'(encoded_count), 32'd11);

        send(I_TYPE, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        send(I_TYPE, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        rst = 1'b1;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_instr", instruction, 32'd0);
        check("async_count", 32'(encoded_count), 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        send(I_TYPE, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFF800);
        expect_head("post_rst", 32'h80010093, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
